txn_frontend: RTL and testbench

Client-side responder for the memory controller request port. It accepts read/write requests over the in_valid/out_busy handshake and tags each one with an ID. Requests are issued in order to the controller core, whose completions may return out of order. A reorder buffer retires completions strictly in acceptance order, pulsing write_done, or read_done with data_out.

---
 rtl/txn_frontend_pkg.sv | 21 ++
 rtl/txn_rob_mem.sv | 82 ++++++++
 rtl/txn_frontend.sv | 133 +++++++++++++
 tb/tb_txn_frontend.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/txn_frontend_pkg.sv
// rtl/txn_frontend_pkg.sv - shared types and default sizes for the transaction front end
package txn_frontend_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 30;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_type_e;

    typedef struct packed {
        req_type_e               req_type;
        logic [DEF_ADDR_W-1:0]   addr;
        logic [DEF_DATA_W-1:0]   data;
        logic                    issued;
        logic                    done;
    } rob_entry_t;

endpackage

// File: rtl/txn_rob_mem.sv
// rtl/txn_rob_mem.sv - reorder-buffer register file with alloc/issue/completion/free ports
module txn_rob_mem
    import txn_frontend_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ID_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_en,
    input  logic [ID_W-1:0]   alloc_idx,
    input  req_type_e         alloc_type,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic [DATA_W-1:0] alloc_data,
    input  logic              issue_en,
    input  logic [ID_W-1:0]   issue_idx,
    input  logic              cpl_en,
    input  logic [ID_W-1:0]   cpl_idx,
    input  logic [DATA_W-1:0] cpl_data,
    input  logic              free_en,
    input  logic [ID_W-1:0]   retire_idx,
    output req_type_e         issue_type,
    output logic [ADDR_W-1:0] issue_addr,
    output logic [DATA_W-1:0] issue_data,
    output req_type_e         retire_type,
    output logic [DATA_W-1:0] retire_data,
    output logic [DEPTH-1:0]  issued_vec,
    output logic [DEPTH-1:0]  done_vec
);

    req_type_e          type_q [DEPTH];
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]   issued_q;
    logic [DEPTH-1:0]   done_q;

    // Entry updates; the four write ports never target the same entry in one cycle,
    // free is last so a same-cycle completion of the retiring head cannot linger.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i] <= READ;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            issued_q <= '0;
            done_q   <= '0;
        end else begin
            if (alloc_en) begin
                type_q[alloc_idx]   <= alloc_type;
                addr_q[alloc_idx]   <= alloc_addr;
                data_q[alloc_idx]   <= alloc_data;
                issued_q[alloc_idx] <= 1'b0;
                done_q[alloc_idx]   <= 1'b0;
            end
            if (issue_en) begin
                issued_q[issue_idx] <= 1'b1;
            end
            if (cpl_en) begin
                done_q[cpl_idx] <= 1'b1;
                if (type_q[cpl_idx] == READ) begin
                    data_q[cpl_idx] <= cpl_data;
                end
            end
            if (free_en) begin
                issued_q[retire_idx] <= 1'b0;
                done_q[retire_idx]   <= 1'b0;
            end
        end
    end

    assign issue_type  = type_q[issue_idx];
    assign issue_addr  = addr_q[issue_idx];
    assign issue_data  = data_q[issue_idx];
    assign retire_type = type_q[retire_idx];
    assign retire_data = data_q[retire_idx];
    assign issued_vec  = issued_q;
    assign done_vec    = done_q;

endmodule

// File: rtl/txn_frontend.sv
// rtl/txn_frontend.sv - in-order request issue with out-of-order completion reordering
module txn_frontend
    import txn_frontend_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ID_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_request_type,
    input  logic [ADDR_W-1:0] in_request_address,
    input  logic [DATA_W-1:0] in_request_data,
    output logic              out_busy,
    output logic              write_done,
    output logic              read_done,
    output logic [DATA_W-1:0] data_out,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_type,
    output logic [ADDR_W-1:0] req_address,
    output logic [DATA_W-1:0] req_data,
    output logic [ID_W-1:0]   req_id,
    input  logic              rsp_valid,
    input  logic [ID_W-1:0]   rsp_id,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              proto_err
);

    localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(DEPTH);

    logic [ID_W-1:0]   alloc_ptr;
    logic [ID_W-1:0]   issue_ptr;
    logic [ID_W-1:0]   retire_ptr;
    logic [ID_W:0]     count;
    logic              full;
    logic              accept;
    logic              issue_fire;
    logic              rsp_ok;
    logic              head_bypass;
    logic              retire_fire;
    logic [DATA_W-1:0] retire_sel;
    req_type_e         issue_type;
    req_type_e         retire_type;
    logic [DATA_W-1:0] retire_data;
    logic [DEPTH-1:0]  issued_vec;
    logic [DEPTH-1:0]  done_vec;

    assign full     = (count == FULL_CNT);
    assign out_busy = full;
    assign accept   = in_valid && !full;

    // When full with issue_ptr == alloc_ptr, the head slot tells us whether nothing or everything is issued.
    assign req_valid  = (issue_ptr != alloc_ptr) || (full && !issued_vec[issue_ptr]);
    assign issue_fire = req_valid && req_ready;
    assign req_type   = issue_type;
    assign req_id     = issue_ptr;

    // A completion of the head retires directly, taking its data from rsp_data.
    assign rsp_ok      = rsp_valid && issued_vec[rsp_id] && !done_vec[rsp_id];
    assign head_bypass = rsp_ok && (rsp_id == retire_ptr);
    assign retire_fire = done_vec[retire_ptr] || head_bypass;
    assign retire_sel  = done_vec[retire_ptr] ? retire_data : rsp_data;

    txn_rob_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .ID_W   (ID_W)
    ) u_mem (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_en    (accept),
        .alloc_idx   (alloc_ptr),
        .alloc_type  (req_type_e'(in_request_type)),
        .alloc_addr  (in_request_address),
        .alloc_data  (in_request_data),
        .issue_en    (issue_fire),
        .issue_idx   (issue_ptr),
        .cpl_en      (rsp_ok && !head_bypass),
        .cpl_idx     (rsp_id),
        .cpl_data    (rsp_data),
        .free_en     (retire_fire),
        .retire_idx  (retire_ptr),
        .issue_type  (issue_type),
        .issue_addr  (req_address),
        .issue_data  (req_data),
        .retire_type (retire_type),
        .retire_data (retire_data),
        .issued_vec  (issued_vec),
        .done_vec    (done_vec)
    );

    // Pointer/occupancy bookkeeping, registered retire pulses and sticky protocol error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alloc_ptr  <= '0;
            issue_ptr  <= '0;
            retire_ptr <= '0;
            count      <= '0;
            write_done <= 1'b0;
            read_done  <= 1'b0;
            data_out   <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (accept) begin
                alloc_ptr <= alloc_ptr + ID_W'(1);
            end
            if (issue_fire) begin
                issue_ptr <= issue_ptr + ID_W'(1);
            end
            if (retire_fire) begin
                retire_ptr <= retire_ptr + ID_W'(1);
            end
            case ({accept, retire_fire})
                2'b10:   count <= count + (ID_W+1)'(1);
                2'b01:   count <= count - (ID_W+1)'(1);
                default: count <= count;
            endcase
            write_done <= retire_fire && (retire_type == WRITE);
            read_done  <= retire_fire && (retire_type == READ);
            if (retire_fire && (retire_type == READ)) begin
                data_out <= retire_sel;
            end
            if (rsp_valid && !rsp_ok) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_txn_frontend.sv
// tb/tb_txn_frontend.sv - directed and randomized-core self-checking bench for txn_frontend
module tb_txn_frontend;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 30;
    localparam int ID_W   = 4;
    localparam int NTXN   = 1023;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_request_type;
    logic [ADDR_W-1:0] in_request_address;
    logic [DATA_W-1:0] in_request_data;
    logic              out_busy;
    logic              write_done;
    logic              read_done;
    logic [DATA_W-1:0] data_out;
    logic              req_valid;
    logic              req_ready;
    logic              req_type;
    logic [ADDR_W-1:0] req_address;
    logic [DATA_W-1:0] req_data;
    logic [ID_W-1:0]   req_id;
    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    int             wr_seen;
    int             rd_seen;
    bit             t5_done;
    logic [DATA_W-1:0] model_mem [1024];
    int             pend_id [$];
    logic [DATA_W-1:0] pend_dat [$];

    txn_frontend dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_request_type    (in_request_type),
        .in_request_address (in_request_address),
        .in_request_data    (in_request_data),
        .out_busy           (out_busy),
        .write_done         (write_done),
        .read_done          (read_done),
        .data_out           (data_out),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_type           (req_type),
        .req_address        (req_address),
        .req_data           (req_data),
        .req_id             (req_id),
        .rsp_valid          (rsp_valid),
        .rsp_id             (rsp_id),
        .rsp_data           (rsp_data),
        .proto_err          (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic t, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        in_valid           = 1'b1;
        in_request_type    = t;
        in_request_address = a;
        in_request_data    = d;
    endtask

    task automatic idle_req();
        in_valid           = 1'b0;
        in_request_type    = 1'b0;
        in_request_address = '0;
        in_request_data    = '0;
    endtask

    task automatic apply_reset();
        idle_req();
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        rsp_data  = '0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
    endtask

    task automatic check_idle(input string p);
        check({p, "_busy"},  out_busy,    0);
        check({p, "_wdone"}, write_done,  0);
        check({p, "_rdone"}, read_done,   0);
        check({p, "_dout"},  data_out,    0);
        check({p, "_rvld"},  req_valid,   0);
        check({p, "_rtyp"},  req_type,    0);
        check({p, "_raddr"}, req_address, 0);
        check({p, "_rdata"}, req_data,    0);
        check({p, "_rid"},   req_id,      0);
        check({p, "_perr"},  proto_err,   0);
    endtask

    initial begin
        logic [ID_W-1:0]   ooo_id  [3];
        logic [DATA_W-1:0] ooo_dat [3];
        int pulses;

        idle_req();
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        rsp_data  = '0;
        rst_n     = 1'b0;
        tick();
        tick();
        check_idle("rst");
        rst_n = 1'b1;

        // 1: single write, completion three cycles after issue
        req_ready = 1'b1;
        drive_req(1'b1, 30'd2, 16'd10);
        tick();
        idle_req();
        check("t1_rvld", req_valid, 1);
        check("t1_rid", req_id, 0);
        check("t1_rtyp", req_type, 1);
        check("t1_raddr", req_address, 2);
        check("t1_rdata", req_data, 10);
        tick();
        check("t1_rvld_after", req_valid, 0);
        tick();
        check("t1_wdone_early", write_done, 0);
        tick();
        rsp_valid = 1'b1;
        rsp_id    = 4'd0;
        tick();
        rsp_valid = 1'b0;
        check("t1_wdone", write_done, 1);
        check("t1_rdone", read_done, 0);
        tick();
        check("t1_wdone_once", write_done, 0);

        // 2: write then read of same address
        drive_req(1'b1, 30'd2, 16'd10);
        tick();
        drive_req(1'b0, 30'd2, 16'd0);
        tick();
        idle_req();
        check("t2_rid", req_id, 2);
        check("t2_rtyp", req_type, 0);
        tick();
        rsp_valid = 1'b1;
        rsp_id    = 4'd1;
        tick();
        check("t2_wdone", write_done, 1);
        check("t2_rdone_early", read_done, 0);
        rsp_id   = 4'd2;
        rsp_data = 16'd10;
        tick();
        rsp_valid = 1'b0;
        check("t2_rdone", read_done, 1);
        check("t2_dout", data_out, 10);
        check("t2_wdone_off", write_done, 0);

        // 3: fill with req_ready low, 17th request dropped
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            drive_req(1'b0, ADDR_W'(i), 16'd0);
            tick();
            if (i == 14) check("t3_busy15", out_busy, 0);
            if (i == 15) check("t3_busy16", out_busy, 1);
        end
        idle_req();
        check("t3_count", dut.count, 16);
        check("t3_busy", out_busy, 1);
        check("t3_rvld", req_valid, 1);
        check("t3_rid", req_id, 0);
        check("t3_raddr", req_address, 0);
        tick();
        tick();
        check("t3_rvld_hold", req_valid, 1);
        check("t3_rid_hold", req_id, 0);
        req_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("t3_order", req_address, k);
            tick();
        end
        req_ready = 1'b0;
        check("t3_no17th", req_valid, 0);
        rsp_valid = 1'b1;
        rsp_id    = 4'd0;
        rsp_data  = 16'hAB;
        tick();
        rsp_valid = 1'b0;
        check("t3_full_rdone", read_done, 1);
        check("t3_full_dout", data_out, 16'hAB);
        check("t3_busy_fall", out_busy, 0);
        check("t3_count_dec", dut.count, 15);

        // 4: out-of-order completion 3,1,2,0 retires in order
        apply_reset();
        req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b0, ADDR_W'(i), 16'd0);
            tick();
        end
        idle_req();
        tick();
        ooo_id[0] = 4'd3; ooo_dat[0] = 16'h33;
        ooo_id[1] = 4'd1; ooo_dat[1] = 16'h11;
        ooo_id[2] = 4'd2; ooo_dat[2] = 16'h22;
        for (int i = 0; i < 3; i++) begin
            rsp_valid = 1'b1;
            rsp_id    = ooo_id[i];
            rsp_data  = ooo_dat[i];
            tick();
            check("t4_hold", read_done, 0);
        end
        rsp_id   = 4'd0;
        rsp_data = 16'h00;
        tick();
        rsp_valid = 1'b0;
        check("t4_rdone0", read_done, 1);
        check("t4_dout0", data_out, 16'h00);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("t4_rdone", read_done, 1);
            check("t4_dout", data_out, 16'h11 * k);
        end
        tick();
        check("t4_rdone_end", read_done, 0);

        // 6: completion for an un-issued tag, then reset with work outstanding
        rsp_valid = 1'b1;
        rsp_id    = 4'd5;
        rsp_data  = 16'h55;
        tick();
        rsp_valid = 1'b0;
        check("t6_perr", proto_err, 1);
        check("t6_rdone", read_done, 0);
        check("t6_wdone", write_done, 0);
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, ADDR_W'(i), DATA_W'(i));
            tick();
        end
        idle_req();
        tick();
        check("t6_outstanding", dut.count, 4);
        req_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle("t6_rst");
        check("t6_count", dut.count, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(write_done) + int'(read_done);
        end
        check("t6_no_pulses", pulses, 0);

        // 5: long stream through a randomized out-of-order core
        apply_reset();
        wr_seen = 0;
        rd_seen = 0;
        t5_done = 1'b0;
        pend_id.delete();
        pend_dat.delete();
        fork
            begin : producer
                int guard;
                for (int i = 0; i < 2 * NTXN; i++) begin
                    drive_req(i < NTXN, ADDR_W'(i % NTXN), (i < NTXN) ? DATA_W'(i) : DATA_W'(0));
                    guard = 0;
                    while (out_busy && guard < 5000 && !t5_done) begin
                        tick();
                        guard++;
                    end
                    tick();
                end
                idle_req();
            end
            begin : core
                bit                hs;
                logic [ID_W-1:0]   h_id;
                logic              h_type;
                logic [ADDR_W-1:0] h_addr;
                logic [DATA_W-1:0] h_data;
                int                k;
                while (!t5_done) begin
                    req_ready = ($urandom_range(0, 3) != 0);
                    hs     = req_valid && req_ready;
                    h_id   = req_id;
                    h_type = req_type;
                    h_addr = req_address;
                    h_data = req_data;
                    if (pend_id.size() > 0 && $urandom_range(0, 3) != 0) begin
                        k = $urandom_range(0, pend_id.size() - 1);
                        rsp_valid = 1'b1;
                        rsp_id    = ID_W'(pend_id[k]);
                        rsp_data  = pend_dat[k];
                        pend_id.delete(k);
                        pend_dat.delete(k);
                    end else begin
                        rsp_valid = 1'b0;
                        rsp_data  = DATA_W'($urandom);
                    end
                    if (hs) begin
                        if (h_type) begin
                            model_mem[h_addr[9:0]] = h_data;
                            pend_dat.push_back(DATA_W'($urandom));
                        end else begin
                            pend_dat.push_back(model_mem[h_addr[9:0]]);
                        end
                        pend_id.push_back(int'(h_id));
                    end
                    tick();
                end
                rsp_valid = 1'b0;
                req_ready = 1'b0;
            end
            begin : monitor
                int cyc;
                cyc = 0;
                while (rd_seen < NTXN && cyc < 40000) begin
                    tick();
                    cyc++;
                    if (write_done) wr_seen++;
                    if (read_done) begin
                        if (rd_seen == 0) check("t5_wr_before_rd", wr_seen, NTXN);
                        check("t5_rdata", data_out, rd_seen);
                        rd_seen++;
                    end
                end
                check("t5_reads", rd_seen, NTXN);
                check("t5_writes", wr_seen, NTXN);
                check("t5_perr", proto_err, 0);
                t5_done = 1'b1;
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
